// File: rtl/shift_reg_mem.sv
// Shift-register memory: a DEPTH-entry line of WIDTH-bit words with per-entry valid
// tracking, a registered shift-out port and a registered random-access tap read.
module shift_reg_mem #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_en,
  input  logic             write_enable,
  input  logic [WIDTH-1:0] write_data,
  input  logic             flush,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             rd_hit,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic [CW-1:0]    count,
  output logic             full
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_hit_q, rd_hit_d;
  logic             rd_valid_q, rd_valid_d;

  logic addr_ok_s;
  logic word_in_s;
  logic word_out_s;

  // Non-power-of-2 DEPTH leaves tap addresses with no backing entry.
  assign addr_ok_s  = (32'(rd_addr) < 32'(DEPTH));
  // Write-in-place only adds a valid word when entry 0 was empty.
  assign word_in_s  = write_enable & (shift_en | ~vld_q[0]);
  assign word_out_s = shift_en & vld_q[DEPTH-1];

  always_comb begin
    mem_d       = mem_q;
    vld_d       = vld_q;
    count_d     = count_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    rd_data_d   = rd_data_q;
    rd_hit_d    = rd_hit_q;
    rd_valid_d  = 1'b0;

    // Tap read always sees pre-update state, flush included.
    if (rd_en) begin
      rd_valid_d = 1'b1;
      if (addr_ok_s) begin
        rd_data_d = mem_q[rd_addr];
        rd_hit_d  = vld_q[rd_addr];
      end else begin
        rd_data_d = {WIDTH{1'b0}};
        rd_hit_d  = 1'b0;
      end
    end else begin
      rd_valid_d = 1'b0;
    end

    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_d[i] = {WIDTH{1'b0}};
      end
      vld_d   = {DEPTH{1'b0}};
      count_d = {CW{1'b0}};
    end else begin
      if (shift_en) begin
        for (int i = DEPTH - 1; i > 0; i--) begin
          mem_d[i] = mem_q[i-1];
        end
        mem_d[0]    = write_enable ? write_data : {WIDTH{1'b0}};
        vld_d       = {vld_q[DEPTH-2:0], write_enable};
        out_data_d  = mem_q[DEPTH-1];
        out_valid_d = vld_q[DEPTH-1];
      end else if (write_enable) begin
        mem_d[0] = write_data;
        vld_d[0] = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end

      if (word_in_s && !word_out_s) begin
        count_d = count_q + CW'(1);
      end else if (!word_in_s && word_out_s) begin
        count_d = count_q - CW'(1);
      end else begin
        count_d = count_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      vld_q       <= {DEPTH{1'b0}};
      count_q     <= {CW{1'b0}};
      out_data_q  <= {WIDTH{1'b0}};
      out_valid_q <= 1'b0;
      rd_data_q   <= {WIDTH{1'b0}};
      rd_hit_q    <= 1'b0;
      rd_valid_q  <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      vld_q       <= vld_d;
      count_q     <= count_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      rd_data_q   <= rd_data_d;
      rd_hit_q    <= rd_hit_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_hit    = rd_hit_q;
  assign rd_valid  = rd_valid_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign count     = count_q;
  assign full      = (count_q == CW'(DEPTH));

endmodule

// File: tb/tb_shift_reg_mem.sv
// Bench for shift_reg_mem (DEPTH=4, WIDTH=8): directed scenarios with literal
// expectations, then randomized traffic against a queue-based line model.
module tb_shift_reg_mem;
  localparam int W  = 8;
  localparam int D  = 4;
  localparam int AW = $clog2(D);
  localparam int CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          reset, shift_en, write_enable, flush, rd_en;
  logic [W-1:0]  write_data;
  logic [AW-1:0] rd_addr;
  logic [W-1:0]  rd_data, out_data;
  logic          rd_valid, rd_hit, out_valid, full;
  logic [CW-1:0] count;

  int tests_run = 0;
  int failed    = 0;

  // reference line: index 0 is the newest entry
  logic [W-1:0] m_data[$];
  bit           m_vld[$];
  logic [W-1:0] e_out_data, e_rd_data;
  bit           e_out_valid, e_rd_hit, e_rd_valid;
  int           e_count;

  shift_reg_mem #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .shift_en(shift_en), .write_enable(write_enable),
    .write_data(write_data), .flush(flush), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_hit(rd_hit), .out_data(out_data),
    .out_valid(out_valid), .count(count), .full(full)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reset = 1'b0; shift_en = 1'b0; write_enable = 1'b0; flush = 1'b0;
    rd_en = 1'b0; write_data = 8'h00; rd_addr = 2'd0;
  endtask

  task automatic model_clear();
    m_data.delete(); m_vld.delete();
    for (int i = 0; i < D; i++) begin
      m_data.push_back(8'h00); m_vld.push_back(1'b0);
    end
  endtask

  task automatic model_step();
    if (reset) begin
      model_clear();
      e_out_data = 8'h00; e_out_valid = 1'b0;
      e_rd_data = 8'h00; e_rd_hit = 1'b0; e_rd_valid = 1'b0;
    end else begin
      e_rd_valid = rd_en;
      if (rd_en) begin
        if (int'(rd_addr) < D) begin
          e_rd_data = m_data[rd_addr]; e_rd_hit = m_vld[rd_addr];
        end else begin
          e_rd_data = 8'h00; e_rd_hit = 1'b0;
        end
      end
      e_out_valid = 1'b0;
      if (flush) begin
        model_clear();
      end else if (shift_en) begin
        e_out_data  = m_data.pop_back();
        e_out_valid = m_vld.pop_back();
        m_data.push_front(write_enable ? write_data : 8'h00);
        m_vld.push_front(write_enable);
      end else if (write_enable) begin
        m_data[0] = write_data; m_vld[0] = 1'b1;
      end
    end
    e_count = 0;
    foreach (m_vld[i]) e_count += int'(m_vld[i]);
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (5) tick();
    tests_run++;
    if (count !== 3'd0 || full !== 1'b0) begin
      failed++; $display("FAIL reset_count count=%0d full=%0b want 0/0", count, full);
    end
    tests_run++;
    if (out_valid !== 1'b0 || rd_valid !== 1'b0 || rd_hit !== 1'b0) begin
      failed++; $display("FAIL reset_flags ov=%0b rv=%0b rh=%0b want 0", out_valid, rd_valid, rd_hit);
    end
    tests_run++;
    if (out_data !== 8'h00 || rd_data !== 8'h00) begin
      failed++; $display("FAIL reset_data out=%h rd=%h want 00", out_data, rd_data);
    end
  endtask

  task automatic test_fill_drain();
    logic [W-1:0] words [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    idle_inputs();
    shift_en = 1'b1; write_enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      write_data = words[i];
      tick();
      tests_run++;
      if (int'(count) !== i + 1) begin
        failed++; $display("FAIL fill_count step=%0d got=%0d want=%0d", i, count, i + 1);
      end
    end
    tests_run++;
    if (full !== 1'b1) begin
      failed++; $display("FAIL fill_full got=%0b want=1", full);
    end
    write_enable = 1'b0; write_data = 8'h00;
    for (int i = 0; i < 4; i++) begin
      tick();
      tests_run++;
      if (out_data !== words[i] || out_valid !== 1'b1 || int'(count) !== 3 - i) begin
        failed++;
        $display("FAIL drain step=%0d out=%h ov=%0b cnt=%0d want %h/1/%0d",
                 i, out_data, out_valid, count, words[i], 3 - i);
      end
    end
    idle_inputs();
    tick();
    tests_run++;
    if (out_valid !== 1'b0 || out_data !== 8'h44) begin
      failed++; $display("FAIL drain_idle ov=%0b out=%h want 0/44", out_valid, out_data);
    end
  endtask

  task automatic test_zero_insert();
    idle_inputs();
    shift_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      tests_run++;
      if (out_valid !== 1'b0 || count !== 3'd0) begin
        failed++; $display("FAIL zero_shift step=%0d ov=%0b cnt=%0d want 0/0", i, out_valid, count);
      end
    end
    idle_inputs();
    rd_en = 1'b1; rd_addr = 2'd0;
    tick();
    tests_run++;
    if (rd_data !== 8'h00 || rd_hit !== 1'b0 || rd_valid !== 1'b1) begin
      failed++; $display("FAIL zero_read rd=%h hit=%0b rv=%0b want 00/0/1", rd_data, rd_hit, rd_valid);
    end
  endtask

  task automatic test_write_in_place();
    idle_inputs();
    write_enable = 1'b1; write_data = 8'h5A;
    tick();
    write_data = 8'hA5;
    tick();
    tests_run++;
    if (count !== 3'd1 || out_valid !== 1'b0) begin
      failed++; $display("FAIL wip_count cnt=%0d ov=%0b want 1/0", count, out_valid);
    end
    idle_inputs();
    rd_en = 1'b1; rd_addr = 2'd0;
    tick();
    tests_run++;
    if (rd_data !== 8'hA5 || rd_hit !== 1'b1 || rd_valid !== 1'b1) begin
      failed++; $display("FAIL wip_read rd=%h hit=%0b rv=%0b want a5/1/1", rd_data, rd_hit, rd_valid);
    end
    idle_inputs();
    tick();
    tests_run++;
    if (rd_valid !== 1'b0 || rd_data !== 8'hA5 || rd_hit !== 1'b1) begin
      failed++; $display("FAIL read_hold rv=%0b rd=%h hit=%0b want 0/a5/1", rd_valid, rd_data, rd_hit);
    end
  endtask

  task automatic test_rbw_shift();
    idle_inputs();
    write_enable = 1'b1; write_data = 8'h11;
    tick();
    rd_en = 1'b1; rd_addr = 2'd0; shift_en = 1'b1; write_data = 8'h77;
    tick();
    tests_run++;
    if (rd_data !== 8'h11 || rd_hit !== 1'b1 || count !== 3'd2) begin
      failed++; $display("FAIL rbw_shift rd=%h hit=%0b cnt=%0d want 11/1/2", rd_data, rd_hit, count);
    end
    idle_inputs();
    rd_en = 1'b1; rd_addr = 2'd0;
    tick();
    tests_run++;
    if (rd_data !== 8'h77 || rd_hit !== 1'b1) begin
      failed++; $display("FAIL rbw_next rd=%h hit=%0b want 77/1", rd_data, rd_hit);
    end
  endtask

  task automatic test_flush();
    // line is [77,11,--,--]; two more writes fill it to [99,88,77,11]
    idle_inputs();
    shift_en = 1'b1; write_enable = 1'b1; write_data = 8'h88;
    tick();
    write_data = 8'h99;
    tick();
    tests_run++;
    if (full !== 1'b1 || count !== 3'd4) begin
      failed++; $display("FAIL flush_pre full=%0b cnt=%0d want 1/4", full, count);
    end
    flush = 1'b1; write_data = 8'h77; rd_en = 1'b1; rd_addr = 2'd3;
    tick();
    tests_run++;
    if (rd_data !== 8'h11 || rd_hit !== 1'b1) begin
      failed++; $display("FAIL flush_read rd=%h hit=%0b want 11/1", rd_data, rd_hit);
    end
    tests_run++;
    if (count !== 3'd0 || full !== 1'b0 || out_valid !== 1'b0) begin
      failed++; $display("FAIL flush_clear cnt=%0d full=%0b ov=%0b want 0/0/0", count, full, out_valid);
    end
    idle_inputs();
    rd_en = 1'b1; rd_addr = 2'd0;
    tick();
    tests_run++;
    if (rd_data !== 8'h00 || rd_hit !== 1'b0) begin
      failed++; $display("FAIL flush_lost rd=%h hit=%0b want 00/0", rd_data, rd_hit);
    end
  endtask

  task automatic test_random();
    idle_inputs();
    reset = 1'b1;
    model_step();
    tick();
    for (int n = 0; n < 400; n++) begin
      reset        = ($urandom_range(63) == 0);
      flush        = ($urandom_range(15) == 0);
      shift_en     = $urandom_range(1);
      write_enable = $urandom_range(1);
      rd_en        = $urandom_range(1);
      write_data   = W'($urandom);
      rd_addr      = AW'($urandom);
      model_step();
      tick();
      tests_run++;
      if (out_data !== e_out_data || out_valid !== e_out_valid || int'(count) !== e_count ||
          full !== (e_count == D)) begin
        failed++;
        $display("FAIL rand_out cyc=%0d out=%h ov=%0b cnt=%0d full=%0b want %h/%0b/%0d",
                 n, out_data, out_valid, count, full, e_out_data, e_out_valid, e_count);
      end
      tests_run++;
      if (rd_valid !== e_rd_valid || (e_rd_valid && (rd_data !== e_rd_data || rd_hit !== e_rd_hit))) begin
        failed++;
        $display("FAIL rand_rd cyc=%0d rv=%0b rd=%h hit=%0b want %0b/%h/%0b",
                 n, rd_valid, rd_data, rd_hit, e_rd_valid, e_rd_data, e_rd_hit);
      end
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_fill_drain();
    test_zero_insert();
    test_write_in_place();
    test_rbw_shift();
    test_flush();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end
endmodule
